// File: rtl/mem_bus_ctrl_if.sv
// Core-side request/response channel of the memory bus controller.
// The core drives requests; the controller answers with a one-cycle pulse.
interface mem_bus_ctrl_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid,
    output req_addr,
    output req_we,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_we,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding ROM/RAM bus controller with per-region wait states.
// Region is taken from the external decoder in the first access cycle.
module mem_bus_ctrl #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int ROM_WAIT = 2,
  parameter int RAM_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_ctrl_if.slave     bus,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              rom_sel,
  input  logic              ram_sel,
  output logic              rom_cs,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] rom_rdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    RG_ROM,
    RG_RAM,
    RG_ERR
  } region_e;

  state_e            state_q, state_d;
  region_e           region_q, region_d;
  region_e           region_dec, region_now;
  logic              first_q, first_d;
  logic              we_q, we_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        wait_now;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  always_comb begin
    region_dec = RG_ERR;
    unique case (1'b1)
      (rom_sel && !ram_sel && !we_q): region_dec = RG_ROM;
      (ram_sel && !rom_sel):          region_dec = RG_RAM;
      default:                        region_dec = RG_ERR;
    endcase
  end

  // First access cycle uses the live decode; later cycles the latched one.
  always_comb begin
    region_now = first_q ? region_dec : region_q;
    wait_now   = cnt_q;
    if (first_q) begin
      unique case (region_dec)
        RG_ROM:  wait_now = 3'(ROM_WAIT);
        RG_RAM:  wait_now = 3'(RAM_WAIT);
        default: wait_now = 3'd0;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    region_d      = region_q;
    first_d       = 1'b0;
    we_d          = we_q;
    cnt_d         = cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    bus.req_ready = 1'b0;
    rom_cs        = 1'b0;
    ram_cs        = 1'b0;
    ram_we        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          mem_addr_d  = bus.req_addr;
          mem_wdata_d = bus.req_wdata;
          we_d        = bus.req_we;
          first_d     = 1'b1;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        region_d = region_now;
        rom_cs   = (region_now == RG_ROM);
        ram_cs   = (region_now == RG_RAM);
        ram_we   = ram_cs && we_q;
        if (wait_now == 3'd0) begin
          cnt_d       = 3'd0;
          rsp_err_d   = (region_now == RG_ERR);
          rsp_rdata_d = '0;
          if (rom_cs) rsp_rdata_d = rom_rdata;
          if (ram_cs && !we_q) rsp_rdata_d = ram_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = wait_now - 3'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      region_q    <= RG_ERR;
      first_q     <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= 3'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      first_q     <= first_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized bench for mem_bus_ctrl against a transaction-level model.
// Bench supplies the decoder, ROM and RAM around the controller.
module tb_mem_bus_ctrl;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int ROM_W = 2;
  localparam int RAM_W = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_addr;
  logic          rom_sel, ram_sel;
  logic          rom_cs, ram_cs, ram_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] rom_rdata, ram_rdata;
  logic [1:0]    fault = 2'd0;

  logic [DW-1:0] rom_mem [0:8191];
  logic [DW-1:0] ram_mem [0:8191];
  logic [DW-1:0] shadow [int];

  int n_tests = 0;
  int n_fail  = 0;

  mem_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_bus_ctrl #(
    .ADDR_W(AW), .DATA_W(DW),
    .ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mem_addr(mem_addr),
    .rom_sel(rom_sel), .ram_sel(ram_sel),
    .rom_cs(rom_cs), .ram_cs(ram_cs), .ram_we(ram_we),
    .mem_wdata(mem_wdata),
    .rom_rdata(rom_rdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Decoder model with fault injection: 1 = both selects, 2 = none.
  always_comb begin
    rom_sel = (mem_addr < 13'h1800);
    ram_sel = (mem_addr >= 13'h1800);
    if (fault == 2'd1) begin
      rom_sel = 1'b1;
      ram_sel = 1'b1;
    end else if (fault == 2'd2) begin
      rom_sel = 1'b0;
      ram_sel = 1'b0;
    end
  end

  assign rom_rdata = rom_cs ? rom_mem[mem_addr] : 32'hBAD0BAD0;
  assign ram_rdata = ram_cs ? ram_mem[mem_addr] : 32'hBAD1BAD1;

  always @(posedge clk)
    if (ram_cs && ram_we) ram_mem[mem_addr] <= mem_wdata;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ram_ref(input int a);
    return shadow.exists(a) ? shadow[a] : 32'h0;
  endfunction

  task automatic do_txn(input logic [AW-1:0] addr,
                        input logic we,
                        input logic [DW-1:0] wd,
                        input logic [1:0] flt);
    bit is_rom, err, seen;
    int w, lat, rom_n, ram_n, we_n, first_cs, bad_addr;
    logic [31:0] exp_rd, rd;
    logic er;
    is_rom = (addr < 13'h1800);
    err    = (flt != 2'd0) || (is_rom && we);
    w      = err ? 0 : (is_rom ? ROM_W : RAM_W);
    if (err || we) exp_rd = 0;
    else if (is_rom) exp_rd = rom_mem[addr];
    else exp_rd = ram_ref(int'(addr));
    seen = 0; lat = 0; rom_n = 0; ram_n = 0; we_n = 0;
    first_cs = 0; bad_addr = 0; rd = 0; er = 0;
    @(negedge clk);
    fault = flt;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_we    = we;
    bus.req_wdata = wd;
    check("ready_idle", 32'(bus.req_ready), 1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.req_addr = $urandom;
    bus.req_wdata = $urandom;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (rom_cs) rom_n++;
      if (ram_cs) ram_n++;
      if (ram_we) we_n++;
      if ((rom_cs || ram_cs) && first_cs == 0) first_cs = c;
      if (mem_addr !== addr || (we && mem_wdata !== wd))
        bad_addr++;
      if (bus.req_ready) bad_addr++;
      if (bus.rsp_valid) begin
        seen = 1; lat = c;
        rd = bus.rsp_rdata; er = bus.rsp_err;
        break;
      end
    end
    check("rsp_seen", 32'(seen), 1);
    check("latency", lat, w + 2);
    check("rom_cs_n", rom_n, (!err && is_rom) ? w + 1 : 0);
    check("ram_cs_n", ram_n, (!err && !is_rom) ? w + 1 : 0);
    check("ram_we_n", we_n, (!err && !is_rom && we) ? w + 1 : 0);
    check("cs_start", first_cs, err ? 0 : 1);
    check("bus_stable", bad_addr, 0);
    check("rsp_err", 32'(er), 32'(err));
    check("rsp_rdata", rd, exp_rd);
    @(negedge clk);
    fault = 2'd0;
    check("rsp_pulse", 32'(bus.rsp_valid), 0);
    check("ready_back", 32'(bus.req_ready), 1);
    check("rdata_hold", bus.rsp_rdata, exp_rd);
    if (!err && !is_rom && we) shadow[int'(addr)] = wd;
  endtask

  initial begin
    int acc[2];
    int rsp_c[2];
    logic [31:0] rsp_d[2];
    int acc_n, rsp_n, busy_bad, bad;
    for (int i = 0; i < 8192; i++) begin
      rom_mem[i] = $urandom;
      ram_mem[i] = 32'h0;
    end
    rom_mem[4] = 32'hDEADBEEF;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_we    = 1'b0;
    bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    check("rst_err", 32'(bus.rsp_err), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_cs", {29'd0, rom_cs, ram_cs, ram_we}, 0);

    do_txn(13'h0004, 1'b0, 32'h0, 2'd0);
    do_txn(13'h1810, 1'b1, 32'h12345678, 2'd0);
    do_txn(13'h1810, 1'b0, 32'h0, 2'd0);
    do_txn(13'h1000, 1'b1, 32'hCAFEF00D, 2'd0);
    do_txn(13'h1900, 1'b0, 32'h0, 2'd1);
    do_txn(13'h17FF, 1'b0, 32'h0, 2'd0);
    do_txn(13'h1800, 1'b1, 32'hA5A5A5A5, 2'd0);
    do_txn(13'h1800, 1'b0, 32'h0, 2'd0);
    do_txn(13'h0100, 1'b0, 32'h0, 2'd2);

    // Back-to-back: req_valid held high across two transactions.
    shadow[13'h1FFC] = 32'h0BADC0DE;
    ram_mem[13'h1FFC] = 32'h0BADC0DE;
    acc_n = 0; rsp_n = 0; busy_bad = 0;
    acc[0] = -1; acc[1] = -1;
    rsp_c[0] = -1; rsp_c[1] = -1;
    rsp_d[0] = 0; rsp_d[1] = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 13'h0000;
    bus.req_we    = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) bus.req_addr = 13'h1FFC;
      if (acc_n == 2 && c == acc[1] + 1) bus.req_valid = 1'b0;
      if (bus.req_valid && bus.req_ready && acc_n < 2) begin
        acc[acc_n] = c;
        acc_n++;
      end
      if (c >= 1 && c <= ROM_W + 2 && bus.req_ready) busy_bad++;
      if (bus.rsp_valid && rsp_n < 2) begin
        rsp_c[rsp_n] = c;
        rsp_d[rsp_n] = bus.rsp_rdata;
        rsp_n++;
      end
    end
    check("b2b_acc0", acc[0], 0);
    check("b2b_rsp0", rsp_c[0], ROM_W + 2);
    check("b2b_acc1", acc[1], rsp_c[0] + 1);
    check("b2b_rsp1", rsp_c[1], ROM_W + 3 + RAM_W + 2);
    check("b2b_busy", busy_bad, 0);
    check("b2b_d0", rsp_d[0], rom_mem[0]);
    check("b2b_d1", rsp_d[1], ram_ref(13'h1FFC));

    // Reset during the second cycle of a ROM read.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 13'h0004;
    bus.req_we    = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("mid_cs_c1", 32'(rom_cs), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_cs_c3", 32'(rom_cs), 0);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.rsp_valid || !bus.req_ready || rom_cs) bad++;
    end
    check("mid_abort", bad, 0);
    do_txn(13'h0004, 1'b0, 32'h0, 2'd0);

    // Reset wins over a simultaneous request.
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 13'h1820;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.rsp_valid || ram_cs || !bus.req_ready) bad++;
    end
    check("rst_prio", bad, 0);

    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      logic [1:0] f;
      if ($urandom_range(0, 1) == 1)
        a = AW'($urandom_range(13'h1800, 13'h1FFF));
      else
        a = AW'($urandom_range(0, 13'h17FF));
      f = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      do_txn(a, 1'($urandom_range(0, 1)), $urandom, f);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
